// File: rtl/md_sched.sv
// Mult/div issue scheduler: launches one multdiv op at a time, tracks its
// destination for RAW stalls, and arbitrates writeback behind the MW stage.
module md_sched (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_valid,
  input  logic        iss_div,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic        flush,
  input  logic [4:0]  rs_a,
  input  logic [4:0]  rs_b,
  output logic        hazard,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic        md_rdy,
  input  logic        md_err,
  input  logic [31:0] md_res,
  input  logic        pipe_we,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  localparam logic [5:0]  TIMEOUT  = 6'd39;
  localparam logic [4:0]  ERR_REG  = 5'd30;
  localparam logic [31:0] ERR_MULT = 32'd4;
  localparam logic [31:0] ERR_DIV  = 32'd5;

  state_t      state;
  logic        div_q;
  logic [4:0]  tgt_q;
  logic [31:0] buf_q;
  logic [5:0]  cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      div_q        <= 1'b0;
      tgt_q        <= '0;
      buf_q        <= '0;
      cnt_q        <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      case (state)
        IDLE: begin
          // Start pulse is registered here so it is high exactly during START.
          if (iss_valid) begin
            div_q        <= iss_div;
            tgt_q        <= iss_rd;
            md_ctrl_mult <= ~iss_div;
            md_ctrl_div  <= iss_div;
            state        <= START;
          end
        end
        START: begin
          cnt_q <= '0;
          state <= flush ? IDLE : BUSY;
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else if (md_rdy && !md_err) begin
            buf_q <= md_res;
            state <= (tgt_q == '0) ? IDLE : DONE;
          end else if (md_rdy || cnt_q == TIMEOUT) begin
            // Error or watchdog expiry reports a status code into r30.
            buf_q <= div_q ? ERR_DIV : ERR_MULT;
            tgt_q <= ERR_REG;
            state <= DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          if (!pipe_we) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iss_ready = (state == IDLE);
    busy      = (state != IDLE);
    hazard    = busy && (tgt_q != '0) && ((rs_a == tgt_q) || (rs_b == tgt_q));
    wb_we     = (state == DONE) && !pipe_we;
    wb_reg    = (state == DONE) ? tgt_q : '0;
    wb_data   = (state == DONE) ? buf_q : '0;
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: directed ops push expected writebacks,
// a negedge monitor pops and compares whenever wb_we is asserted.
module tb_md_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iss_valid = 1'b0, iss_div = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_ready;
  logic        flush = 1'b0;
  logic [4:0]  rs_a = '0, rs_b = '0;
  logic        hazard;
  logic        md_ctrl_mult, md_ctrl_div;
  logic        md_rdy = 1'b0, md_err = 1'b0;
  logic [31:0] md_res = '0;
  logic        pipe_we = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [36:0] sb[$];

  md_sched dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_div(iss_div), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .flush(flush), .rs_a(rs_a), .rs_b(rs_b), .hazard(hazard),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_rdy(md_rdy), .md_err(md_err), .md_res(md_res),
    .pipe_we(pipe_we), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic dv, input logic [4:0] rd);
    iss_valid = 1'b1; iss_div = dv; iss_rd = rd;
    step();
    iss_valid = 1'b0; iss_div = 1'b0; iss_rd = '0;
  endtask

  task automatic complete(input logic [31:0] res, input logic err);
    md_rdy = 1'b1; md_res = res; md_err = err;
    step();
    md_rdy = 1'b0; md_res = '0; md_err = 1'b0;
  endtask

  // Monitor: every writeback must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset && wb_we) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got reg %0d data %0h expected no writeback", wb_reg, wb_data);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        if ({wb_reg, wb_data} !== e) begin
          miscompares++;
          $display("FAIL wb_compare: got reg %0d data %0h expected reg %0d data %0h",
                   wb_reg, wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int n;
    #12;
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {28'd0, wb_we, md_ctrl_mult, md_ctrl_div, hazard}, 32'd0);
    chk("rst_wb", {wb_reg, wb_data[26:0]} | {5'd0, wb_data[31:27], 22'd0}, 32'd0);
    reset = 1'b1;
    step();

    // Basic mult timing: issue cycle 0, result cycle 5, writeback cycle 6
    sb.push_back({5'd7, 32'd42});
    issue(1'b0, 5'd7);
    chk("c1_mult_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd2);
    step();
    chk("c2_pulse_gone", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    chk("c2_busy", {30'd0, busy, iss_ready}, 32'd2);
    step(); step(); step();
    complete(32'd42, 1'b0);
    chk("c6_wb_we", {31'd0, wb_we}, 32'd1);
    chk("c6_wb_data", wb_data, 32'd42);
    step();
    chk("c7_idle", {30'd0, busy, iss_ready}, 32'd1);

    // Div error redirects to r30 with code 5
    sb.push_back({5'd30, 32'd5});
    issue(1'b1, 5'd9);
    chk("div_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd1);
    step(); step();
    complete(32'hDEAD, 1'b1);
    chk("div_err_reg", {27'd0, wb_reg}, 32'd30);
    step();

    // Pipeline priority: DONE held for 3 cycles of pipe_we
    sb.push_back({5'd3, 32'h1234});
    issue(1'b0, 5'd3);
    step(); step();
    pipe_we = 1'b1;
    complete(32'h1234, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_wb_we", {31'd0, wb_we}, 32'd0);
      chk("hold_data", wb_data, 32'h1234);
      chk("hold_iss_ready", {31'd0, iss_ready}, 32'd0);
      if (i < 2) step();
      else begin pipe_we = 1'b0; #1; end
    end
    chk("hold_release", {31'd0, wb_we}, 32'd1);
    step();

    // Hazard on pending rd 12; none for rd 0
    sb.push_back({5'd12, 32'd77});
    issue(1'b0, 5'd12);
    step();
    rs_b = 5'd12; #1;
    chk("haz_rs_b", {31'd0, hazard}, 32'd1);
    rs_b = 5'd0; rs_a = 5'd12; #1;
    chk("haz_rs_a", {31'd0, hazard}, 32'd1);
    rs_a = 5'd0; #1;
    chk("haz_none", {31'd0, hazard}, 32'd0);
    complete(32'd77, 1'b0);
    step();
    issue(1'b0, 5'd0);
    step();
    chk("haz_rd0", {31'd0, hazard}, 32'd0);
    complete(32'd55, 1'b0);
    chk("rd0_direct_idle", {30'd0, busy, wb_we}, 32'd0);

    // Watchdog: no md_rdy, mult -> r30 = 4 after 40 BUSY cycles
    sb.push_back({5'd30, 32'd4});
    issue(1'b0, 5'd5);
    n = 0;
    while (!wb_we && n < 100) begin step(); n++; end
    chk("timeout_cycles", n, 32'd41);
    step();

    // Flush + issue together in IDLE is accepted; flush in DONE has no effect
    sb.push_back({5'd4, 32'd88});
    flush = 1'b1;
    issue(1'b1, 5'd4);
    flush = 1'b0;
    chk("flush_issue_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd1);
    step();
    pipe_we = 1'b1;
    complete(32'd88, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0; pipe_we = 1'b0; #1;
    chk("flush_done_kept", {31'd0, wb_we}, 32'd1);
    step();

    // Flush in BUSY discards the op; late md_rdy ignored
    issue(1'b0, 5'd8);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    complete(32'd99, 1'b0);
    chk("flush_busy_idle", {30'd0, iss_ready, wb_we}, 32'd2);
    step();

    // Reset while in DONE abandons the writeback immediately
    issue(1'b0, 5'd10);
    step();
    pipe_we = 1'b1;
    complete(32'd123, 1'b0);
    chk("pre_rst_done", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    pipe_we = 1'b0; #1;
    chk("rst_done_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_done_idle", {30'd0, busy, iss_ready}, 32'd1);
    step();
    reset = 1'b1;
    complete(32'd321, 1'b0);
    chk("post_rst_rdy_ignored", {30'd0, busy, wb_we}, 32'd0);
    step(); step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
